// File: rtl/tcu_cmd_arbiter.sv
// Round-robin arbiter that hands the TCU command port to one requester for a
// burst of back-to-back commands, driving the TCU side from an output register.
module tcu_cmd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = $clog2(MAX_BURST + 1),
    parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ-1:0][3:0]   req_block_id,
    input  logic [NUM_REQ-1:0][9:0]   req_tid,
    input  logic [NUM_REQ-1:0]        req_write_enable,
    input  logic [NUM_REQ-1:0][63:0]  req_write_data,
    input  logic [NUM_REQ-1:0][7:0]   req_write_mask,
    input  logic [NUM_REQ-1:0][63:0]  req_address,
    input  logic [NUM_REQ-1:0][1:0]   req_size,
    input  logic [NUM_REQ-1:0][6:0]   req_ld_dest_reg,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      incmd_valid,
    output logic [3:0]                incmd_block_id,
    output logic [9:0]                incmd_tid,
    output logic                      incmd_write_enable,
    output logic [63:0]               incmd_write_data,
    output logic [7:0]                incmd_write_mask,
    output logic [63:0]               incmd_address,
    output logic [1:0]                incmd_size,
    output logic [6:0]                incmd_ld_dest_reg,
    input  logic                      incmd_ready,
    output logic                      grant_valid,
    output logic [ID_W-1:0]           grant_id
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  r_owner;
    logic [CNT_W-1:0] r_count;

    state_t           w_state_nxt;
    logic [ID_W-1:0]  w_rr_nxt;
    logic [ID_W-1:0]  w_owner_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_count_inc;
    logic [ID_W-1:0]  w_winner;
    logic [ID_W:0]    w_idx;
    logic             w_found;
    logic             w_slot_free;
    logic             w_accept;

    assign w_count_inc = r_count + CNT_W'(1);
    assign w_slot_free = !incmd_valid || incmd_ready;

    // First valid requester scanning upward from the round-robin pointer.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W + 1)'(i);
            if (w_idx >= (ID_W + 1)'(NUM_REQ)) begin
                w_idx = w_idx - (ID_W + 1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_owner_nxt = r_owner;
        w_count_nxt = r_count;
        w_accept    = 1'b0;
        req_ready   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_LOCKED;
                    w_owner_nxt = w_winner;
                    w_count_nxt = '0;
                end
            end
            ST_LOCKED: begin
                req_ready[r_owner] = w_slot_free;
                w_accept           = req_valid[r_owner] && w_slot_free;
                if (w_accept) begin
                    if (req_last[r_owner] || (w_count_inc == CNT_W'(MAX_BURST))) begin
                        w_state_nxt = ST_IDLE;
                        w_count_nxt = '0;
                        w_rr_nxt    = (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + ID_W'(1);
                    end else begin
                        w_count_nxt = w_count_inc;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_owner  <= w_owner_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // NOTE: the output data fields are reset as well so the TCU never sees stale X data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            incmd_valid        <= 1'b0;
            incmd_block_id     <= '0;
            incmd_tid          <= '0;
            incmd_write_enable <= 1'b0;
            incmd_write_data   <= '0;
            incmd_write_mask   <= '0;
            incmd_address      <= '0;
            incmd_size         <= '0;
            incmd_ld_dest_reg  <= '0;
        end else if (w_accept) begin
            incmd_valid        <= 1'b1;
            incmd_block_id     <= req_block_id[r_owner];
            incmd_tid          <= req_tid[r_owner];
            incmd_write_enable <= req_write_enable[r_owner];
            incmd_write_data   <= req_write_data[r_owner];
            incmd_write_mask   <= req_write_mask[r_owner];
            incmd_address      <= req_address[r_owner];
            incmd_size         <= req_size[r_owner];
            incmd_ld_dest_reg  <= req_ld_dest_reg[r_owner];
        end else if (incmd_ready) begin
            incmd_valid <= 1'b0;
        end
    end

    assign grant_valid = (r_state == ST_LOCKED);
    assign grant_id    = grant_valid ? r_owner : '0;

endmodule

// File: tb/tb_tcu_cmd_arbiter.sv
// Directed bench for tcu_cmd_arbiter (NUM_REQ=4, MAX_BURST=8) with
// hand-derived grant order, timing and command contents.
module tb_tcu_cmd_arbiter;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req_valid;
    logic [3:0]      req_last;
    logic [3:0][3:0] req_block_id;
    logic [3:0][9:0] req_tid;
    logic [3:0]      req_write_enable;
    logic [3:0][63:0] req_write_data;
    logic [3:0][7:0] req_write_mask;
    logic [3:0][63:0] req_address;
    logic [3:0][1:0] req_size;
    logic [3:0][6:0] req_ld_dest_reg;
    logic [3:0]      req_ready;
    logic            incmd_valid;
    logic [3:0]      incmd_block_id;
    logic [9:0]      incmd_tid;
    logic            incmd_write_enable;
    logic [63:0]     incmd_write_data;
    logic [7:0]      incmd_write_mask;
    logic [63:0]     incmd_address;
    logic [1:0]      incmd_size;
    logic [6:0]      incmd_ld_dest_reg;
    logic            incmd_ready;
    logic            grant_valid;
    logic [1:0]      grant_id;
    logic [159:0]    obs_cmd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tcu_cmd_arbiter #(.NUM_REQ(4), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last),
        .req_block_id(req_block_id), .req_tid(req_tid),
        .req_write_enable(req_write_enable), .req_write_data(req_write_data),
        .req_write_mask(req_write_mask), .req_address(req_address),
        .req_size(req_size), .req_ld_dest_reg(req_ld_dest_reg),
        .req_ready(req_ready),
        .incmd_valid(incmd_valid), .incmd_block_id(incmd_block_id),
        .incmd_tid(incmd_tid), .incmd_write_enable(incmd_write_enable),
        .incmd_write_data(incmd_write_data), .incmd_write_mask(incmd_write_mask),
        .incmd_address(incmd_address), .incmd_size(incmd_size),
        .incmd_ld_dest_reg(incmd_ld_dest_reg), .incmd_ready(incmd_ready),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    assign obs_cmd = {incmd_block_id, incmd_tid, incmd_write_enable, incmd_write_data,
                      incmd_write_mask, incmd_address, incmd_size, incmd_ld_dest_reg};

    // Command contents for requester r, sequence number s.
    function automatic logic [159:0] exp_cmd(input int r, input int s);
        logic [3:0]  b;
        logic [9:0]  t;
        logic        we;
        logic [63:0] wd;
        logic [7:0]  m;
        logic [63:0] a;
        logic [1:0]  sz;
        logic [6:0]  ld;
        b  = 4'(r * 3 + s);
        t  = 10'(r * 100 + s);
        we = 1'((s + r) % 2);
        wd = {32'hDA7A_0000 | 32'(r), 32'(s * 17 + 5)};
        m  = 8'(1 << ((s + r) % 8));
        a  = {32'h0000_1000 + 32'(r), 32'(s * 8)};
        sz = 2'(s);
        ld = 7'(r * 20 + s);
        return {b, t, we, wd, m, a, sz, ld};
    endfunction

    task automatic drive(input int r, input int s, input logic last);
        req_valid[r] = 1'b1;
        req_last[r]  = last;
        {req_block_id[r], req_tid[r], req_write_enable[r], req_write_data[r],
         req_write_mask[r], req_address[r], req_size[r], req_ld_dest_reg[r]} = exp_cmd(r, s);
    endtask

    task automatic clear_all();
        req_valid        = '0;
        req_last         = '0;
        req_block_id     = '0;
        req_tid          = '0;
        req_write_enable = '0;
        req_write_data   = '0;
        req_write_mask   = '0;
        req_address      = '0;
        req_size         = '0;
        req_ld_dest_reg  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        incmd_ready = 1'b1;
        clear_all();
        step();
        step();
        checks++; if (incmd_valid !== 1'b0) begin failures++; $display("FAIL reset_incmd_valid got=%b want=0", incmd_valid); end
        checks++; if (obs_cmd !== 160'b0) begin failures++; $display("FAIL reset_incmd_data got=%h want=0", obs_cmd); end
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
        checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL reset_grant_valid got=%b want=0", grant_valid); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id got=%0d want=0", grant_id); end
        rst = 1'b0;
        step();
    endtask

    // Requester 2, three commands, last on the third; rr_ptr then points at 3.
    task automatic test_single();
        drive(2, 0, 1'b0);
        step();
        checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin failures++; $display("FAIL single_grant got=%b/%0d want=1/2", grant_valid, grant_id); end
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b want=0100", req_ready); end
        checks++; if (incmd_valid !== 1'b0) begin failures++; $display("FAIL single_no_cmd_yet got=%b want=0", incmd_valid); end
        for (int s = 0; s < 3; s++) begin
            step();
            checks++; if (incmd_valid !== 1'b1 || obs_cmd !== exp_cmd(2, s)) begin failures++; $display("FAIL single_cmd%0d got=%b/%h want=1/%h", s, incmd_valid, obs_cmd, exp_cmd(2, s)); end
            checks++; if (grant_valid !== (s < 2)) begin failures++; $display("FAIL single_grant_hold%0d got=%b want=%b", s, grant_valid, s < 2); end
            if (s < 2) drive(2, s + 1, s == 1);
        end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL single_grant_id_idle got=%0d want=0", grant_id); end
        clear_all();
        drive(0, 0, 1'b1);
        drive(3, 0, 1'b1);
        step();
        checks++; if (grant_id !== 2'd3) begin failures++; $display("FAIL single_rr_ptr got=%0d want=3", grant_id); end
        checks++; if (incmd_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b want=0", incmd_valid); end
        step();
        checks++; if (obs_cmd !== exp_cmd(3, 0) || grant_valid !== 1'b0) begin failures++; $display("FAIL single_r3_cmd got=%h/%b want=%h/0", obs_cmd, grant_valid, exp_cmd(3, 0)); end
        clear_all();
        step();
    endtask

    // All four valid with single-beat bursts: grants 0,1,2,3,0 every 2 cycles.
    task automatic test_round_robin();
        for (int r = 0; r < 4; r++) drive(r, 5, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (grant_valid !== 1'b1 || grant_id !== 2'(k % 4)) begin failures++; $display("FAIL rr_grant%0d got=%b/%0d want=1/%0d", k, grant_valid, grant_id, k % 4); end
            checks++; if (req_ready !== 4'(1 << (k % 4))) begin failures++; $display("FAIL rr_ready%0d got=%b want=%b", k, req_ready, 4'(1 << (k % 4))); end
            step();
            checks++; if (grant_valid !== 1'b0 || incmd_valid !== 1'b1 || obs_cmd !== exp_cmd(k % 4, 5)) begin failures++; $display("FAIL rr_cmd%0d got=%b/%b/%h want=0/1/%h", k, grant_valid, incmd_valid, obs_cmd, exp_cmd(k % 4, 5)); end
        end
        clear_all();
        step();
    endtask

    // Requester 1 streams without last: forced release after 8, requester 2 served, then 1 again.
    task automatic test_max_burst();
        drive(1, 0, 1'b0);
        drive(2, 9, 1'b1);
        step();
        checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL burst_first_grant got=%0d want=1", grant_id); end
        for (int j = 0; j < 8; j++) begin
            step();
            checks++; if (incmd_valid !== 1'b1 || obs_cmd !== exp_cmd(1, j)) begin failures++; $display("FAIL burst_cmd%0d got=%b/%h want=1/%h", j, incmd_valid, obs_cmd, exp_cmd(1, j)); end
            checks++; if (grant_valid !== (j < 7)) begin failures++; $display("FAIL burst_grant%0d got=%b want=%b", j, grant_valid, j < 7); end
            drive(1, j + 1, 1'b0);
        end
        step();
        checks++; if (grant_id !== 2'd2 || req_ready !== 4'b0100) begin failures++; $display("FAIL burst_next_owner got=%0d/%b want=2/0100", grant_id, req_ready); end
        step();
        checks++; if (obs_cmd !== exp_cmd(2, 9) || grant_valid !== 1'b0) begin failures++; $display("FAIL burst_r2_cmd got=%h/%b want=%h/0", obs_cmd, grant_valid, exp_cmd(2, 9)); end
        req_valid[2] = 1'b0;
        step();
        checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin failures++; $display("FAIL burst_regain got=%b/%0d want=1/1", grant_valid, grant_id); end
        req_valid[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd1 || incmd_valid !== 1'b0) begin failures++; $display("FAIL burst_hold%0d got=%b/%0d/%b want=1/1/0", k, grant_valid, grant_id, incmd_valid); end
        end
        drive(1, 8, 1'b1);
        step();
        checks++; if (obs_cmd !== exp_cmd(1, 8) || grant_valid !== 1'b0) begin failures++; $display("FAIL burst_final got=%h/%b want=%h/0", obs_cmd, grant_valid, exp_cmd(1, 8)); end
        clear_all();
        step();
    endtask

    // TCU stalls for 5 cycles mid-burst: held command stable, no ready, nothing lost.
    task automatic test_backpressure();
        drive(3, 0, 1'b0);
        step();
        checks++; if (grant_id !== 2'd3) begin failures++; $display("FAIL bp_grant got=%0d want=3", grant_id); end
        step();
        drive(3, 1, 1'b0);
        step();
        drive(3, 2, 1'b0);
        incmd_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL bp_ready_low got=%b want=0000", req_ready); end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (incmd_valid !== 1'b1 || obs_cmd !== exp_cmd(3, 1) || req_ready !== 4'b0) begin failures++; $display("FAIL bp_stall%0d got=%b/%h/%b want=1/%h/0000", k, incmd_valid, obs_cmd, req_ready, exp_cmd(3, 1)); end
        end
        incmd_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL bp_ready_resume got=%b want=1000", req_ready); end
        step();
        checks++; if (obs_cmd !== exp_cmd(3, 2)) begin failures++; $display("FAIL bp_cmd2 got=%h want=%h", obs_cmd, exp_cmd(3, 2)); end
        drive(3, 3, 1'b1);
        step();
        checks++; if (incmd_valid !== 1'b1 || obs_cmd !== exp_cmd(3, 3)) begin failures++; $display("FAIL bp_cmd3 got=%b/%h want=1/%h", incmd_valid, obs_cmd, exp_cmd(3, 3)); end
        clear_all();
        step();
        checks++; if (incmd_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b want=0", incmd_valid); end
    endtask

    // last=1 on the 8th beat: one release, arbitration resumes from owner+1.
    task automatic test_last_at_max();
        drive(0, 0, 1'b0);
        drive(1, 4, 1'b1);
        drive(3, 4, 1'b1);
        step();
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL lm_grant got=%0d want=0", grant_id); end
        for (int j = 0; j < 8; j++) begin
            step();
            checks++; if (obs_cmd !== exp_cmd(0, j) || grant_valid !== (j < 7)) begin failures++; $display("FAIL lm_beat%0d got=%h/%b want=%h/%b", j, obs_cmd, grant_valid, exp_cmd(0, j), j < 7); end
            if (j < 7) drive(0, j + 1, j == 6);
            else req_valid[0] = 1'b0;
        end
        step();
        checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin failures++; $display("FAIL lm_next got=%b/%0d want=1/1", grant_valid, grant_id); end
        step();
        req_valid[1] = 1'b0;
        step();
        checks++; if (grant_id !== 2'd3) begin failures++; $display("FAIL lm_after got=%0d want=3", grant_id); end
        step();
        clear_all();
        step();
    endtask

    // Reset while locked with a held command; next grant scans from requester 0.
    task automatic test_reset_mid();
        drive(2, 0, 1'b1);
        step();
        step();
        clear_all();
        drive(3, 0, 1'b0);
        step();
        checks++; if (grant_id !== 2'd3) begin failures++; $display("FAIL rm_pre_grant got=%0d want=3", grant_id); end
        step();
        incmd_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (incmd_valid !== 1'b0 || obs_cmd !== 160'b0) begin failures++; $display("FAIL rm_incmd got=%b/%h want=0/0", incmd_valid, obs_cmd); end
        checks++; if (grant_valid !== 1'b0 || grant_id !== 2'd0 || req_ready !== 4'b0) begin failures++; $display("FAIL rm_grant got=%b/%0d/%b want=0/0/0000", grant_valid, grant_id, req_ready); end
        step();
        rst = 1'b0;
        incmd_ready = 1'b1;
        clear_all();
        drive(1, 0, 1'b1);
        drive(3, 1, 1'b1);
        step();
        checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin failures++; $display("FAIL rm_restart got=%b/%0d want=1/1", grant_valid, grant_id); end
        step();
        checks++; if (obs_cmd !== exp_cmd(1, 0)) begin failures++; $display("FAIL rm_cmd got=%h want=%h", obs_cmd, exp_cmd(1, 0)); end
        clear_all();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_max_burst();
        test_backpressure();
        test_last_at_max();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
